// File: rtl/dec_history_sched_pkg.sv
// Shared types and constants for the decoded-instruction history scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dec_history_sched_pkg;

  localparam int RISCV_ARCH     = 64;
  localparam int DEC_BLOCK      = 4;   // 2 rv + 2 rvc slots per fetched block
  localparam int FULL_DEC_DEPTH = 16;
  localparam int DEC_BLOCKS     = FULL_DEC_DEPTH / DEC_BLOCK;
  localparam int DEC_TAG_W      = RISCV_ARCH - 2;

  // Scheduler FSM encoding
  typedef logic [1:0] dec_sched_state_t;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HIT       = 2'd1;
  localparam logic [1:0] ST_MISS_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH     = 2'd3;

  // Per-block bookkeeping kept alongside d[]
  typedef struct packed {
    logic [DEC_TAG_W-1:0] tag;
    logic [1:0]           rvc;
    logic                 vld;
  } dec_sched_tag_t;

  function automatic logic [DEC_TAG_W-1:0] pc_tag(input logic [RISCV_ARCH-1:0] pc);
    return pc[RISCV_ARCH-1:2];
  endfunction

endpackage

// File: rtl/dec_sched_tag_cam.sv
// Parallel tag compare over all history blocks with lowest-index priority.
// Latency: combinational.
// Backpressure: none.
// Ports: tag_arr/vld_vec = stored block tags and valids, lk_tag = lookup tag,
//        hit = any valid match, blk = lowest matching block index.
module dec_sched_tag_cam
  import dec_history_sched_pkg::*;
#(
  parameter int BLOCKS = DEC_BLOCKS,
  parameter int BW     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
  input  logic [DEC_TAG_W-1:0] tag_arr [BLOCKS],
  input  logic [BLOCKS-1:0]    vld_vec,
  input  logic [DEC_TAG_W-1:0] lk_tag,
  output logic                 hit,
  output logic [BW-1:0]        blk
);

  // Scan from the oldest block down so the newest (lowest index) match wins.
  always_comb begin
    hit = 1'b0;
    blk = '0;
    for (int b = BLOCKS - 1; b >= 0; b--) begin
      if (vld_vec[b] && (tag_arr[b] == lk_tag)) begin
        hit = 1'b1;
        blk = BW'(b);
      end
    end
  end

endmodule

// File: rtl/dec_history_sched.sv
// Tag/valid controller for the decoded-instruction history d[]: shifts in blocks, maps execute PCs to slots.
// Latency: lookup accepted at cycle N -> o_e_valid or o_e_miss at N+1.
// Backpressure: o_e_valid held until i_e_ready; o_f_ready drops only on flush; optional
//               stats ports o_hit_cnt/o_miss_cnt exist when RIVER_DEC_SCHED_STATS_EN is defined.
// Ports: i_clk/i_rst (async active-high), i_flush; fetch side i_f_valid/i_f_pc/i_f_rvc/o_f_ready/o_shift;
//        execute side i_e_req/i_e_pc/o_e_req_rdy/o_e_valid/o_e_idx/o_e_miss/i_e_ready.
module dec_history_sched
  import dec_history_sched_pkg::*;
#(
  parameter int DEPTH = FULL_DEC_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_f_valid,
  input  logic [RISCV_ARCH-1:0]    i_f_pc,
  input  logic [1:0]               i_f_rvc,
  output logic                     o_f_ready,
  output logic                     o_shift,
  input  logic                     i_e_req,
  input  logic [RISCV_ARCH-1:0]    i_e_pc,
  output logic                     o_e_req_rdy,
  output logic                     o_e_valid,
  output logic [$clog2(DEPTH)-1:0] o_e_idx,
  output logic                     o_e_miss,
`ifdef RIVER_DEC_SCHED_STATS_EN
  output logic [31:0]              o_hit_cnt,
  output logic [31:0]              o_miss_cnt,
`endif
  input  logic                     i_e_ready
);

  localparam int BLOCKS = DEPTH / DEC_BLOCK;
  localparam int BW     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int IW     = $clog2(DEPTH);

  dec_sched_tag_t        tags [BLOCKS];
  dec_sched_state_t      state;
  logic [DEC_TAG_W-1:0]  pend_tag;
  logic                  pend_h;

  logic                  f_acc;
  logic                  e_acc;
  logic [DEC_TAG_W-1:0]  new_tag;
  logic [DEC_TAG_W-1:0]  lk_tag;
  logic                  lk_h;
  logic [DEC_TAG_W-1:0]  tag_arr [BLOCKS];
  logic [BLOCKS-1:0]     vld_vec;
  logic                  cam_hit;
  logic [BW-1:0]         cam_blk;
  logic [1:0]            cam_rvc;
  logic                  res_hit;
  logic [IW-1:0]         res_idx;
  int                    blk_eff;
  logic                  lk_hit_done;
  logic                  lk_miss_done;
  logic                  unused_pc_bits;

  // Halfword/byte offset bits of the block PC and byte bit of the request are not part of the tag.
  assign unused_pc_bits = ^{i_f_pc[1:0], i_e_pc[0]};

  assign o_f_ready   = !i_flush && (state != ST_FLUSH);
  assign o_e_req_rdy = (!o_e_valid || i_e_ready) && (state != ST_FLUSH);
  assign f_acc       = i_f_valid && o_f_ready;
  assign o_shift     = f_acc;
  assign e_acc       = i_e_req && o_e_req_rdy;
  assign new_tag     = pc_tag(i_f_pc);

  // A fresh request takes the lookup port; otherwise the pending miss PC keeps probing.
  assign lk_tag = e_acc ? i_e_pc[RISCV_ARCH-1:2] : pend_tag;
  assign lk_h   = e_acc ? i_e_pc[1] : pend_h;

  always_comb begin
    for (int b = 0; b < BLOCKS; b++) begin
      tag_arr[b] = tags[b].tag;
      vld_vec[b] = tags[b].vld;
    end
  end

  dec_sched_tag_cam #(
    .BLOCKS (BLOCKS),
    .BW     (BW)
  ) u_cam (
    .tag_arr (tag_arr),
    .vld_vec (vld_vec),
    .lk_tag  (lk_tag),
    .hit     (cam_hit),
    .blk     (cam_blk)
  );

  assign cam_rvc = tags[cam_blk].rvc;

  // CAM sees pre-shift tags. The incoming block wins outright; otherwise a same-cycle
  // shift moves the matching block one slot older, and falling off the end is a miss.
  always_comb begin
    res_hit = 1'b0;
    res_idx = '0;
    blk_eff = 0;
    if (f_acc && (new_tag == lk_tag)) begin
      res_hit = 1'b1;
      res_idx = IW'(2 * int'(lk_h) + int'(i_f_rvc[lk_h]));
    end else if (cam_hit) begin
      blk_eff = int'(cam_blk) + (f_acc ? 1 : 0);
      if (blk_eff < BLOCKS) begin
        res_hit = 1'b1;
        res_idx = IW'(blk_eff * DEC_BLOCK + 2 * int'(lk_h) + int'(cam_rvc[lk_h]));
      end
    end
  end

  assign lk_hit_done  = !i_flush && res_hit && (e_acc || (state == ST_MISS_WAIT));
  assign lk_miss_done = !i_flush && e_acc && !res_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      pend_tag  <= '0;
      pend_h    <= 1'b0;
      o_e_valid <= 1'b0;
      o_e_idx   <= '0;
      o_e_miss  <= 1'b0;
      for (int b = 0; b < BLOCKS; b++) begin
        tags[b] <= '0;
      end
    end else begin
      o_e_miss <= 1'b0;
      if (i_flush) begin
        state     <= ST_FLUSH;
        o_e_valid <= 1'b0;
        for (int b = 0; b < BLOCKS; b++) begin
          tags[b].vld <= 1'b0;
        end
      end else begin
        if (f_acc) begin
          tags[0] <= '{tag: new_tag, rvc: i_f_rvc, vld: 1'b1};
          for (int b = 1; b < BLOCKS; b++) begin
            tags[b] <= tags[b-1];
          end
        end
        if (lk_hit_done) begin
          o_e_valid <= 1'b1;
          o_e_idx   <= res_idx;
          state     <= ST_HIT;
        end else if (lk_miss_done) begin
          o_e_valid <= 1'b0;
          o_e_miss  <= 1'b1;
          pend_tag  <= i_e_pc[RISCV_ARCH-1:2];
          pend_h    <= i_e_pc[1];
          state     <= ST_MISS_WAIT;
        end else begin
          case (state)
            ST_HIT: begin
              if (i_e_ready) begin
                o_e_valid <= 1'b0;
                state     <= ST_IDLE;
              end
            end
            ST_FLUSH: state <= ST_IDLE;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef RIVER_DEC_SCHED_STATS_EN
  // Saturating lookup statistics; only reset clears them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (lk_hit_done && (o_hit_cnt != '1)) begin
        o_hit_cnt <= o_hit_cnt + 32'd1;
      end
      if (lk_miss_done && (o_miss_cnt != '1)) begin
        o_miss_cnt <= o_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dec_history_sched.sv
// Scoreboard bench for dec_history_sched (DEPTH=16, 4 blocks).
// Latency: expects lookup results one cycle after acceptance.
// Backpressure: i_e_ready held high except around the flush scenario.
module tb_dec_history_sched;
  import dec_history_sched_pkg::*;

  localparam int A = RISCV_ARCH;

  logic          i_clk;
  logic          i_rst;
  logic          i_flush;
  logic          i_f_valid;
  logic [A-1:0]  i_f_pc;
  logic [1:0]    i_f_rvc;
  logic          o_f_ready;
  logic          o_shift;
  logic          i_e_req;
  logic [A-1:0]  i_e_pc;
  logic          o_e_req_rdy;
  logic          o_e_valid;
  logic [3:0]    o_e_idx;
  logic          o_e_miss;
  logic          i_e_ready;
`ifdef RIVER_DEC_SCHED_STATS_EN
  logic [31:0]   o_hit_cnt;
  logic [31:0]   o_miss_cnt;
`endif

  dec_history_sched #(.DEPTH(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_flush),
    .i_f_valid   (i_f_valid),
    .i_f_pc      (i_f_pc),
    .i_f_rvc     (i_f_rvc),
    .o_f_ready   (o_f_ready),
    .o_shift     (o_shift),
    .i_e_req     (i_e_req),
    .i_e_pc      (i_e_pc),
    .o_e_req_rdy (o_e_req_rdy),
    .o_e_valid   (o_e_valid),
    .o_e_idx     (o_e_idx),
    .o_e_miss    (o_e_miss),
`ifdef RIVER_DEC_SCHED_STATS_EN
    .o_hit_cnt   (o_hit_cnt),
    .o_miss_cnt  (o_miss_cnt),
`endif
    .i_e_ready   (i_e_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    bit    miss;
    int    idx;
    int    cyc;
    string name;
  } exp_t;
  exp_t sbq[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_hit(input int idx, input string name);
    exp_t e;
    e.miss = 1'b0; e.idx = idx; e.cyc = cyc + 1; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic exp_miss(input string name);
    exp_t e;
    e.miss = 1'b1; e.idx = 0; e.cyc = cyc + 1; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input bit is_miss, input int idx);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_unexpected: got miss=%0d idx=%0d at cycle %0d, expected no output", is_miss, idx, cyc);
    end else begin
      e = sbq.pop_front();
      check({e.name, "_kind"}, is_miss, e.miss);
      check({e.name, "_cycle"}, cyc, e.cyc);
      if (!e.miss) check({e.name, "_idx"}, idx, e.idx);
    end
  endtask

  // Monitor: one scoreboard entry per miss pulse or completed valid/ready handshake.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_e_miss) sb_pop(1'b1, 0);
      if (o_e_valid && i_e_ready) sb_pop(1'b0, int'(o_e_idx));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_rdy();
    int k;
    for (k = 0; k < 20 && !o_e_req_rdy; k++) tick();
    if (!o_e_req_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_rdy_timeout: got o_e_req_rdy=0 after 20 cycles, expected 1");
    end
  endtask

  task automatic step(input bit fv, input logic [A-1:0] fpc, input logic [1:0] frvc,
                      input bit ev, input logic [A-1:0] epc);
    if (ev) wait_rdy();
    i_f_valid = fv; i_f_pc = fpc; i_f_rvc = frvc;
    i_e_req = ev;   i_e_pc = epc;
    tick();
    i_f_valid = 1'b0;
    i_e_req   = 1'b0;
  endtask

  task automatic push(input logic [A-1:0] pc, input logic [1:0] rvc);
    i_f_valid = 1'b1; i_f_pc = pc; i_f_rvc = rvc;
    #1;
    check("push_shift", o_shift, 1);
    tick();
    i_f_valid = 1'b0;
  endtask

  task automatic lookup(input logic [A-1:0] pc);
    step(1'b0, '0, 2'b00, 1'b1, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_f_valid = 1'b0; i_f_pc = '0; i_f_rvc = 2'b00;
    i_e_req = 1'b0; i_e_pc = '0; i_e_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_e_valid", o_e_valid, 0);
    check("rst_e_miss",  o_e_miss, 0);
    check("rst_shift",   o_shift, 0);
    check("rst_e_idx",   o_e_idx, 0);
    check("rst_f_ready", o_f_ready, 1);
    check("rst_req_rdy", o_e_req_rdy, 1);
    i_rst = 1'b0;
    tick();

    // 1: empty history misses; the block arriving during miss-wait resolves it at slot 0
    exp_miss("s1_miss");
    lookup(64'h100);
    tick(); tick();
    exp_hit(0, "s1_fill");
    push(64'h100, 2'b00);
    tick();

    // 2: rvc-aware slot selection and lowest-block priority
    push(64'h100, 2'b00);
    push(64'h104, 2'b10);
    exp_hit(3, "s2_106");
    lookup(64'h106);
    exp_hit(4, "s2_100");
    lookup(64'h100);
    tick(); tick();
`ifdef RIVER_DEC_SCHED_STATS_EN
    check("stats_hit",  o_hit_cnt, 3);
    check("stats_miss", o_miss_cnt, 1);
`endif

    // 3: fifth push drops the oldest block
    push(64'h100, 2'b00);
    push(64'h104, 2'b00);
    push(64'h108, 2'b00);
    push(64'h10C, 2'b00);
    push(64'h110, 2'b00);
    exp_miss("s3_100");
    lookup(64'h100);
    exp_hit(12, "s3_104");
    lookup(64'h104);
    tick();

    // 4: lookup racing a push; history = 110,10C,108,104 before these pushes
    push(64'h108, 2'b00);
    push(64'h120, 2'b00);
    exp_hit(8, "s4_shift");
    step(1'b1, 64'h124, 2'b00, 1'b1, 64'h108);
    exp_miss("s4_drop");
    step(1'b1, 64'h128, 2'b00, 1'b1, 64'h110);
    tick();

    // 5: flush with a held result and a competing block
    i_e_ready = 1'b0;
    lookup(64'h124);
    @(negedge i_clk);
    check("s5_held_valid", o_e_valid, 1);
    check("s5_held_idx",   o_e_idx, 4);
    @(posedge i_clk);
    #1;
    i_flush = 1'b1; i_f_valid = 1'b1; i_f_pc = 64'h104; i_f_rvc = 2'b00;
    #1;
    check("s5_flush_f_ready", o_f_ready, 0);
    check("s5_flush_shift",   o_shift, 0);
    tick();
    i_flush = 1'b0; i_f_valid = 1'b0;
    @(negedge i_clk);
    check("s5_post_valid",   o_e_valid, 0);
    check("s5_post_f_ready", o_f_ready, 0);
    check("s5_post_req_rdy", o_e_req_rdy, 0);
    i_e_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("s5_idle_f_ready", o_f_ready, 1);
    exp_miss("s5_104");
    lookup(64'h104);
    exp_hit(0, "s5_refill");
    push(64'h104, 2'b00);
    tick();

    // 6: an incoming block beats an older block with the same tag
    push(64'h108, 2'b00);
    exp_hit(1, "s6_newprio");
    step(1'b1, 64'h108, 2'b01, 1'b1, 64'h108);
    repeat (3) tick();

    check("sb_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
